// File: rtl/elevator_car_ctrl_pkg.sv
// Shared definitions for the elevator car controller.
// Holds the floor width, timer width, default timing/floor parameters,
// the FSM state type with its encoded constants, and a 3-way floor compare.
package elevator_car_ctrl_pkg;

   localparam int FLOOR_W = 4;
   localparam int TIMER_W = 16;

   localparam int unsigned DEF_TRAVEL_CYCLES = 8;
   localparam int unsigned DEF_DOOR_CYCLES   = 16;
   localparam int unsigned DEF_TOP_FLOOR     = 9;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_UP   = 2'd1;
   localparam state_t ST_DOWN = 2'd2;
   localparam state_t ST_DOOR = 2'd3;

   typedef enum logic [1:0] {
      CmpLess,
      CmpEqual,
      CmpGreater
   } floor_cmp_t;

   // Unsigned compare of a requested floor against the car position.
   function automatic floor_cmp_t floor_cmp(input logic [FLOOR_W-1:0] dest,
                                            input logic [FLOOR_W-1:0] here);
      if (dest > here) begin
         return CmpGreater;
      end else if (dest < here) begin
         return CmpLess;
      end
      return CmpEqual;
   endfunction

endpackage

// File: rtl/elevator_car_ctrl_if.sv
// Request/status bundle between a floor-request source and the car controller.
//   req_valid/req_floor : request offered by the source
//   req_ready           : controller can take a request this cycle
//   cur_floor           : floor the car is at, or last passed
//   move_up/move_down   : car travelling
//   door_open           : door open
//   arrived             : one-cycle pulse on reaching the target
//   req_err             : one-cycle pulse after an out-of-range request
interface elevator_car_ctrl_if;
   import elevator_car_ctrl_pkg::*;

   logic               req_valid;
   logic [FLOOR_W-1:0] req_floor;
   logic               req_ready;
   logic [FLOOR_W-1:0] cur_floor;
   logic               move_up;
   logic               move_down;
   logic               door_open;
   logic               arrived;
   logic               req_err;

   modport master (
      output req_valid,
      output req_floor,
      input  req_ready,
      input  cur_floor,
      input  move_up,
      input  move_down,
      input  door_open,
      input  arrived,
      input  req_err
   );

   modport slave (
      input  req_valid,
      input  req_floor,
      output req_ready,
      output cur_floor,
      output move_up,
      output move_down,
      output door_open,
      output arrived,
      output req_err
   );

endinterface

// File: rtl/elevator_car_ctrl_cycle_timer.sv
// Loadable down-counter shared by travel and door intervals.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : interval length in cycles
//   done       : high during the last cycle of the loaded interval
module elevator_car_ctrl_cycle_timer
   import elevator_car_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic               done
);

   logic [TIMER_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - TIMER_W'(1);
      end
   end

   // Loaded with N, the count reads N..1 over N cycles; 1 marks the final one.
   assign done = (count_q == TIMER_W'(1));

endmodule

// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: IDLE / UP / DOWN / DOOR with a one-entry
// pending request buffer.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/status bundle (slave side), see elevator_car_ctrl_if
module elevator_car_ctrl
   import elevator_car_ctrl_pkg::*;
#(
   parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
   parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES,
   parameter int unsigned TOP_FLOOR     = DEF_TOP_FLOOR
) (
   input  logic                 clk,
   input  logic                 rst_n,
   elevator_car_ctrl_if.slave   bus
);

   localparam logic [FLOOR_W-1:0] TopFloor   = FLOOR_W'(TOP_FLOOR);
   localparam logic [TIMER_W-1:0] TravelLoad = TIMER_W'(TRAVEL_CYCLES);
   localparam logic [TIMER_W-1:0] DoorLoad   = TIMER_W'(DOOR_CYCLES);

   state_t             state_q, state_d;
   logic [FLOOR_W-1:0] cur_q, cur_d;
   logic [FLOOR_W-1:0] tgt_q, tgt_d;
   logic [FLOOR_W-1:0] pend_floor_q, pend_floor_d;
   logic               pend_valid_q, pend_valid_d;
   logic               arrived_q, arrived_d;
   logic               err_q, err_d;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_done;

   logic               accept;
   logic               in_range;
   logic               good_req;
   logic               disp_en;
   logic [FLOOR_W-1:0] disp_floor;

   assign accept   = bus.req_valid && bus.req_ready;
   assign in_range = (bus.req_floor <= TopFloor);
   assign good_req = accept && in_range;

   elevator_car_ctrl_cycle_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      tgt_d        = tgt_q;
      pend_floor_d = pend_floor_q;
      pend_valid_d = pend_valid_q;
      arrived_d    = 1'b0;
      err_d        = accept && !in_range;
      tmr_load     = 1'b0;
      tmr_val      = TravelLoad;
      disp_en      = 1'b0;
      disp_floor   = '0;

      case (state_q)
         ST_IDLE: begin
            if (good_req) begin
               disp_en    = 1'b1;
               disp_floor = bus.req_floor;
            end
         end
         ST_UP, ST_DOWN: begin
            if (good_req) begin
               pend_valid_d = 1'b1;
               pend_floor_d = bus.req_floor;
            end
            if (tmr_done) begin
               if (state_q == ST_UP) begin
                  if (cur_q < TopFloor) cur_d = cur_q + FLOOR_W'(1);
               end else begin
                  if (cur_q != '0) cur_d = cur_q - FLOOR_W'(1);
               end
               tmr_load = 1'b1;
               if (cur_d == tgt_q) begin
                  state_d   = ST_DOOR;
                  arrived_d = 1'b1;
                  tmr_val   = DoorLoad;
               end
            end
         end
         ST_DOOR: begin
            if (tmr_done) begin
               // A request taken on the final door cycle is served like a pending one.
               if (pend_valid_q) begin
                  disp_en      = 1'b1;
                  disp_floor   = pend_floor_q;
                  pend_valid_d = 1'b0;
               end else if (good_req) begin
                  disp_en    = 1'b1;
                  disp_floor = bus.req_floor;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (good_req) begin
               pend_valid_d = 1'b1;
               pend_floor_d = bus.req_floor;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (disp_en) begin
         tgt_d    = disp_floor;
         tmr_load = 1'b1;
         case (floor_cmp(disp_floor, cur_q))
            CmpGreater: begin
               state_d = ST_UP;
               tmr_val = TravelLoad;
            end
            CmpLess: begin
               state_d = ST_DOWN;
               tmr_val = TravelLoad;
            end
            default: begin
               state_d   = ST_DOOR;
               arrived_d = 1'b1;
               tmr_val   = DoorLoad;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cur_q        <= '0;
         tgt_q        <= '0;
         pend_floor_q <= '0;
         pend_valid_q <= 1'b0;
         arrived_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         tgt_q        <= tgt_d;
         pend_floor_q <= pend_floor_d;
         pend_valid_q <= pend_valid_d;
         arrived_q    <= arrived_d;
         err_q        <= err_d;
      end
   end

   // Gated by rst_n so ready stays low while reset is held.
   assign bus.req_ready = rst_n && ((state_q == ST_IDLE) || !pend_valid_q);
   assign bus.cur_floor = cur_q;
   assign bus.move_up   = (state_q == ST_UP);
   assign bus.move_down = (state_q == ST_DOWN);
   assign bus.door_open = (state_q == ST_DOOR);
   assign bus.arrived   = arrived_q;
   assign bus.req_err   = err_q;

endmodule

// File: doc/elevator_car_ctrl.md
ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8, clock cycles spent moving between adjacent floors (>=2).
REQ-002 Parameter DOOR_CYCLES, default 16, clock cycles the door stays open on arrival (>=2).
REQ-003 Parameter TOP_FLOOR, default 9, highest valid floor number (0..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  floor request offered this cycle.
REQ-007 req_floor  input  4  requested floor, unsigned.
REQ-008 req_ready  output  1  controller can accept a request this cycle.
REQ-009 cur_floor  output  4  floor the car is at, or last passed.
REQ-010 move_up  output  1  car travelling upward.
REQ-011 move_down  output  1  car travelling downward.
REQ-012 door_open  output  1  door open.
REQ-013 arrived  output  1  one-cycle pulse when the car reaches its target.
REQ-014 req_err  output  1  one-cycle pulse when an accepted request is out of range.

Function
REQ-015 A request SHALL transfer on any cycle where req_valid and req_ready are both 1; at no other time.
REQ-016 States SHALL be IDLE, UP, DOWN, DOOR; one-hot or encoded, designer's choice.
REQ-017 req_ready SHALL be 1 in IDLE and while the one-entry pending buffer is empty in UP, DOWN or DOOR; 0 otherwise.
REQ-018 A request accepted outside IDLE SHALL be held in the pending buffer and become the target when DOOR completes.
REQ-019 A request with req_floor > TOP_FLOOR SHALL be accepted, discarded, and pulse req_err the next cycle; no state change.
REQ-020 IDLE with target > cur_floor SHALL enter UP next cycle; target < cur_floor SHALL enter DOWN; target == cur_floor SHALL enter DOOR and pulse arrived.
REQ-021 In UP/DOWN, cur_floor SHALL increment/decrement by 1 every TRAVEL_CYCLES cycles after state entry.
REQ-022 On the cycle cur_floor updates to equal target, state SHALL become DOOR and arrived SHALL pulse in that cycle.
REQ-023 cur_floor SHALL never exceed TOP_FLOOR nor go below 0; no wrap-around.
REQ-024 move_up=1 only in UP, move_down=1 only in DOWN, door_open=1 only in DOOR; never two at once.
REQ-025 DOOR SHALL last exactly DOOR_CYCLES cycles, then go to IDLE, or directly to UP/DOWN/DOOR per REQ-020 rules if the pending buffer is full.
REQ-026 A request accepted the same cycle DOOR expires SHALL be treated as pending and served with no idle cycle.
REQ-027 A request equal to the current target while moving SHALL be accepted and served as a new visit after DOOR.
REQ-028 Floor comparison SHALL be 4-bit unsigned, yielding greater/less/equal.

Reset
REQ-029 On rst_n low: state IDLE, cur_floor 0, target 0, pending buffer empty, timer 0, all outputs 0 except req_ready 0 during reset, 1 on first cycle after release.
REQ-030 Reset asserted mid-travel or mid-door SHALL abandon the operation immediately; no arrived pulse.

Structure
REQ-031 Shared package SHALL hold the state type, FLOOR_W=4, and default TRAVEL_CYCLES/DOOR_CYCLES/TOP_FLOOR.
REQ-032 One sub-module, cycle_timer (loadable down-counter with done flag), SHALL time both travel and door intervals.

Verification
REQ-033 Reset, request floor 3 -> move_up 3*8 cycles, cur_floor 1,2,3, arrived pulse, door_open 16 cycles, IDLE.
REQ-034 From floor 5, request 2 -> move_down, cur_floor 4,3,2, arrived at 24 cycles, door then IDLE.
REQ-035 At floor 0 idle, request 0 -> DOOR next cycle, arrived pulse, no motion.
REQ-036 Request 12 with TOP_FLOOR 9 -> req_err pulse, cur_floor and state unchanged.
REQ-037 During UP to 4, request 1 accepted, third request sees req_ready 0 -> after door at 4, DOWN to 1 with no IDLE cycle.
REQ-038 Assert rst_n low mid-travel at floor 2 -> all outputs cleared asynchronously, cur_floor 0, no arrived.
